pipe_stage_vr: RTL and testbench

Parametrised elastic pipeline register with valid/ready handshake and synchronous flush, replacing fixed always-enabled stage registers between pipeline stages (e.g. MEM→WB) so a downstream stall back-pressures upstream without a global enable. It carries an opaque WIDTH-bit payload, tracks per-entry valid bits and, with the skid buffer compiled in, sustains one transfer per cycle with a fully registered `in_ready`.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/flop_en_rst_cl.sv | 25 ++
 rtl/pipe_stage_vr.sv | 132 +++++++++++++
 tb/tb_pipe_stage_vr.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions: architectural width and the elastic pipeline stage state encoding.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    // Number of held entries implied by a stage state.
    function automatic logic [1:0] state_occ(input pipe_state_e s);
        logic [1:0] n;
        n = 2'd0;
        case (s)
            BUSY:    n = 2'd1;
            FULL:    n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/flop_en_rst_cl.sv
// Enabled register with asynchronous active-high reset and synchronous clear, both to RESET_VAL.
module flop_en_rst_cl #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (clr) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_vr.sv
// Elastic valid/ready pipeline register with synchronous flush.
// Define PIPE_STAGE_VR_SKID_EN for the two-entry skid build with a fully registered in_ready.
module pipe_stage_vr
    import riscv_pkg::*;
#(
    parameter int               WIDTH     = riscv_pkg::XLEN,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occ
);

    pipe_state_e      state_q;
    pipe_state_e      state_d;
    logic             in_fire;
    logic             out_fire;
    logic             main_en;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;

`ifdef PIPE_STAGE_VR_SKID_EN
    logic             skid_en;
    logic             main_from_skid;
    logic [WIDTH-1:0] skid_q;

    // Depends only on the state register, so no path from out_ready.
    assign in_ready = (state_q != FULL);
    assign main_d   = main_from_skid ? skid_q : in_data;
`else
    assign in_ready = !out_valid || out_ready;
    assign main_d   = in_data;
`endif

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occ       = state_occ(state_q);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
`ifdef PIPE_STAGE_VR_SKID_EN
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
`endif
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = BUSY;
                    main_en = 1'b1;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_en = 1'b1;
                end else if (in_fire) begin
`ifdef PIPE_STAGE_VR_SKID_EN
                    // Younger entry parks in skid; main keeps the older one.
                    state_d = FULL;
                    skid_en = 1'b1;
`endif
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
`ifdef PIPE_STAGE_VR_SKID_EN
            FULL: begin
                if (out_fire) begin
                    state_d        = BUSY;
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
`endif
            default: state_d = EMPTY;
        endcase

        // Flush wins: drop held entries and any same-cycle input transfer.
        if (flush) begin
            state_d = EMPTY;
            main_en = 1'b0;
`ifdef PIPE_STAGE_VR_SKID_EN
            skid_en = 1'b0;
`endif
        end
    end

    flop_en_rst_cl #(
        .WIDTH    (WIDTH),
        .RESET_VAL(RESET_VAL)
    ) u_main (
        .clk(clk),
        .rst(rst),
        .en (main_en),
        .clr(1'b0),
        .d  (main_d),
        .q  (main_q)
    );

`ifdef PIPE_STAGE_VR_SKID_EN
    flop_en_rst_cl #(
        .WIDTH    (WIDTH),
        .RESET_VAL(RESET_VAL)
    ) u_skid (
        .clk(clk),
        .rst(rst),
        .en (skid_en),
        .clr(1'b0),
        .d  (in_data),
        .q  (skid_q)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_vr.sv
// Scoreboard bench for pipe_stage_vr; works for both the default and PIPE_STAGE_VR_SKID_EN builds.
module tb_pipe_stage_vr;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [1:0]   occ;

    int           n_checks = 0;
    int           n_fail = 0;
    int           exp_occ = 0;
    logic         last_acc = 1'b0;
    logic [W-1:0] q[$];

    pipe_stage_vr #(
        .WIDTH    (W),
        .RESET_VAL('0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .occ      (occ)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every delivered payload must be the oldest outstanding accepted one.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %h expected no output", out_data);
            end else begin
                check("scoreboard", out_data, q.pop_front());
            end
        end
    end

    // One clock cycle: check handshake state against the occupancy model, record
    // transfers at the negedge, then advance to just after the next rising edge.
    task automatic step();
        logic exp_rdy;
        @(negedge clk);
`ifdef PIPE_STAGE_VR_SKID_EN
        exp_rdy = (exp_occ < 2);
`else
        exp_rdy = (exp_occ == 0) || out_ready;
`endif
        check("occ", 32'(occ), 32'(exp_occ));
        check("out_valid", 32'(out_valid), 32'(exp_occ != 0));
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        last_acc = in_valid && exp_rdy;
        if (flush) begin
            q.delete();
            exp_occ = 0;
        end else begin
            if (last_acc) begin
                q.push_back(in_data);
                exp_occ++;
            end
            if (exp_occ > 0 && out_ready && !(last_acc && exp_occ == 1 && 0)) begin
                if (!(last_acc && exp_occ == 1)) exp_occ--;
                else exp_occ = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values while rst is held.
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_occ", 32'(occ), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single transfer, one-cycle latency.
        in_valid  = 1'b1;
        in_data   = 32'h0000_00A5;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("a5_out_valid", 32'(out_valid), 32'd1);
        check("a5_out_data", out_data, 32'h0000_00A5);
        check("a5_occ", 32'(occ), 32'd1);
        step();
        step();

        // Back-to-back stream with no bubbles.
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            step();
            check("stream_data", out_data, 32'(i));
            check("stream_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        step();
        step();

        // Back-pressure: fill, hold the extra offer, then release in order.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        step();
`ifdef PIPE_STAGE_VR_SKID_EN
        in_data = 32'h22;
        step();
        in_data = 32'h33;
        check("bp_occ", 32'(occ), 32'd2);
`else
        in_data = 32'h22;
        check("bp_occ", 32'(occ), 32'd1);
`endif
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_data", out_data, 32'h11);
        step();
        check("bp_held", 32'(last_acc), 32'd0);
        out_ready = 1'b1;
        last_acc  = 1'b0;
        for (int k = 0; k < 10 && !last_acc; k++) step();
        check("bp_accepted", 32'(last_acc), 32'd1);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();

        // Flush from the fullest state with a simultaneous offer.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h44;
        step();
`ifdef PIPE_STAGE_VR_SKID_EN
        in_data = 32'h55;
        step();
`endif
        flush   = 1'b1;
        in_data = 32'h99;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_occ", 32'(occ), 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) step();

        // Random valid/ready with stable offers until accepted.
        last_acc = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if (!in_valid || last_acc) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 32'h1000 + 32'(c);
            end
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) step();

        // Asynchronous reset mid-cycle while holding entries.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h66;
        step();
`ifdef PIPE_STAGE_VR_SKID_EN
        in_data = 32'h77;
        step();
`endif
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data", out_data, 32'd0);
        check("arst_occ", 32'(occ), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        exp_occ = 0;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) step();

        check("drain_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
